alarm_controller: RTL and testbench

//  Downstream consumer of the 24-hour clock. Watches the packed BCD time
//  (HH:MM:SS, 24 bits) that the clock produces. Holds a programmable alarm

---
 rtl/alarm_controller_if.sv | 26 ++
 rtl/alarm_controller.sv | 153 +++++++++++++++
 tb/tb_alarm_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alarm_controller_if.sv
// Alarm controller bus: time/alarm inputs and user controls from the master side,
// stored alarm and status back from the controller.
interface alarm_controller_if;
  logic [23:0] time_in;
  logic [23:0] alarm_in;
  logic        alarm_set;
  logic        alarm_en;
  logic        snooze;
  logic        stop;
  logic [23:0] alarm_time;
  logic        ringing;
  logic [1:0]  state;
  logic [1:0]  snooze_cnt;
  logic        set_err;
  logic        missed;

  modport master (
    output time_in, alarm_in, alarm_set, alarm_en, snooze, stop,
    input  alarm_time, ringing, state, snooze_cnt, set_err, missed
  );

  modport slave (
    input  time_in, alarm_in, alarm_set, alarm_en, snooze, stop,
    output alarm_time, ringing, state, snooze_cnt, set_err, missed
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: watches the BCD time of day, rings at the stored alarm time,
// handles snooze (limited count) and an unanswered-ring timeout. One cycle = one second.
module alarm_controller #(
  parameter int unsigned SNOOZE_SEC   = 300,
  parameter int unsigned RING_TIMEOUT = 60,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  alarm_controller_if.slave bus
);

  localparam int unsigned RingW = $clog2(RING_TIMEOUT + 1);
  localparam int unsigned SnzW  = $clog2(SNOOZE_SEC + 1);

  localparam logic [RingW-1:0] RingLast = RingW'(RING_TIMEOUT - 1);
  localparam logic [SnzW-1:0]  SnzLast  = SnzW'(SNOOZE_SEC - 1);
  // snooze_cnt is a 2-bit output, so the limit is held at that width
  localparam logic [1:0]       MaxSnz   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StArmed    = 2'b01,
    StRinging  = 2'b10,
    StSnoozing = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      alarm_q, alarm_d;
  logic [23:0]      prev_time_q;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;
  logic [1:0]       snooze_cnt_q, snooze_cnt_d;
  logic             set_err_q, set_err_d;
  logic             missed_q, missed_d;

  logic alarm_valid;
  logic set_ok;
  logic set_bad;
  logic match;

  function automatic logic bcd_time_valid(input logic [23:0] t);
    return (t[23:20] <= 4'd2) && (t[19:16] <= 4'd9) && (t[23:16] <= 8'h23) &&
           (t[15:12] <= 4'd5) && (t[11:8]  <= 4'd9) &&
           (t[7:4]   <= 4'd5) && (t[3:0]   <= 4'd9);
  endfunction

  assign alarm_valid = bcd_time_valid(bus.alarm_in);
  assign set_ok      = bus.alarm_set && alarm_valid;
  assign set_bad     = bus.alarm_set && !alarm_valid;
  // Edge-detect on arrival so a held or re-set clock fires only once, and a jump
  // past the alarm never fires.
  assign match       = (bus.time_in == alarm_q) && (prev_time_q != alarm_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      alarm_q      <= 24'h000000;
      prev_time_q  <= 24'h000000;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      snooze_cnt_q <= 2'd0;
      set_err_q    <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_q      <= alarm_d;
      prev_time_q  <= bus.time_in;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      set_err_q    <= set_err_d;
      missed_q     <= missed_d;
    end
  end

  // Next-state: enable, then alarm load, then stop, snooze, match/timers
  always_comb begin
    state_d      = state_q;
    alarm_d      = alarm_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    set_err_d    = set_bad;
    missed_d     = missed_q;

    // Loading happens even when disabled; only the state is forced to idle.
    if (set_ok) begin
      alarm_d      = bus.alarm_in;
      ring_cnt_d   = '0;
      snz_cnt_d    = '0;
      snooze_cnt_d = 2'd0;
      missed_d     = 1'b0;
    end

    if (bus.stop) begin
      missed_d = 1'b0;
    end

    if (!bus.alarm_en) begin
      state_d = StIdle;
    end else if (set_ok) begin
      state_d = StArmed;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArmed;
        end
        StArmed: begin
          if (match) begin
            state_d      = StRinging;
            ring_cnt_d   = '0;
            snooze_cnt_d = 2'd0;
          end
        end
        StRinging: begin
          ring_cnt_d = ring_cnt_q + RingW'(1);
          if (bus.stop) begin
            state_d      = StArmed;
            snooze_cnt_d = 2'd0;
          end else if (bus.snooze && (snooze_cnt_q < MaxSnz)) begin
            state_d      = StSnoozing;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
            snz_cnt_d    = '0;
          end else if (ring_cnt_q == RingLast) begin
            state_d  = StArmed;
            missed_d = 1'b1;
          end
        end
        StSnoozing: begin
          snz_cnt_d = snz_cnt_q + SnzW'(1);
          if (bus.stop) begin
            state_d      = StArmed;
            snooze_cnt_d = 2'd0;
          end else if (snz_cnt_q == SnzLast) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.alarm_time = alarm_q;
  assign bus.ringing    = (state_q == StRinging);
  assign bus.state      = state_q;
  assign bus.snooze_cnt = snooze_cnt_q;
  assign bus.set_err    = set_err_q;
  assign bus.missed     = missed_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: each driven cycle pushes its expected
// outputs; a monitor pops and compares them just after the clock edge.
module tb_alarm_controller;

  localparam int unsigned SnoozeSec   = 5;
  localparam int unsigned RingTimeout = 4;
  localparam int unsigned MaxSnooze   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alarm_controller_if bus();

  alarm_controller #(
    .SNOOZE_SEC  (SnoozeSec),
    .RING_TIMEOUT(RingTimeout),
    .MAX_SNOOZE  (MaxSnooze)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [1:0]  state;
    logic        ringing;
    logic [1:0]  snooze_cnt;
    logic        set_err;
    logic        missed;
    logic [23:0] alarm_time;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   now;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h = s / 3600;
    int m = (s / 60) % 60;
    int x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input string tag, input logic [23:0] t, input logic set,
                      input logic [23:0] ain, input logic sn, input logic st,
                      input logic [1:0] es, input logic [1:0] esc, input logic eerr,
                      input logic emiss, input logic [23:0] ealarm);
    exp_t e;
    bus.time_in   = t;
    bus.alarm_set = set;
    bus.alarm_in  = ain;
    bus.snooze    = sn;
    bus.stop      = st;
    e.tag        = tag;
    e.state      = es;
    e.ringing    = (es == 2'b10);
    e.snooze_cnt = esc;
    e.set_err    = eerr;
    e.missed     = emiss;
    e.alarm_time = ealarm;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".state"},      bus.state,      e.state);
        check({e.tag, ".ringing"},    bus.ringing,    e.ringing);
        check({e.tag, ".snooze_cnt"}, bus.snooze_cnt, e.snooze_cnt);
        check({e.tag, ".set_err"},    bus.set_err,    e.set_err);
        check({e.tag, ".missed"},     bus.missed,     e.missed);
        check({e.tag, ".alarm_time"}, bus.alarm_time, e.alarm_time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] walk [4];
    walk = '{24'h235959, 24'h000000, 24'h000001, 24'h000002};

    bus.time_in   = 24'h0;
    bus.alarm_in  = 24'h0;
    bus.alarm_set = 1'b0;
    bus.alarm_en  = 1'b0;
    bus.snooze    = 1'b0;
    bus.stop      = 1'b0;

    #3;
    check("reset.state",      bus.state,      2'b00);
    check("reset.ringing",    bus.ringing,    1'b0);
    check("reset.alarm_time", bus.alarm_time, 24'h000000);
    check("reset.snooze_cnt", bus.snooze_cnt, 2'd0);
    check("reset.set_err",    bus.set_err,    1'b0);
    check("reset.missed",     bus.missed,     1'b0);
    #5;
    reset_n = 1'b1;
    @(posedge clk);
    #2;

    step("idle", 24'h000000, 0, 24'h0, 0, 0, 2'b00, 2'd0, 0, 0, 24'h000000);
    bus.alarm_en = 1'b1;

    // Alarm at 00:00:03 across midnight
    step("t1.set", 24'h235958, 1, 24'h000003, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000003);
    for (int i = 0; i < 4; i++)
      step("t1.armed", walk[i], 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000003);
    step("t1.ring", 24'h000003, 0, 24'h0, 0, 0, 2'b10, 2'd0, 0, 0, 24'h000003);

    // Three snoozes, each ringing again five edges later
    now = 3;
    for (int i = 1; i <= 3; i++) begin
      now++;
      step("t2.snooze", to_bcd(now), 0, 24'h0, 1, 0, 2'b11, 2'(i), 0, 0, 24'h000003);
      for (int k = 0; k < 4; k++) begin
        now++;
        step("t2.wait", to_bcd(now), 0, 24'h0, 0, 0, 2'b11, 2'(i), 0, 0, 24'h000003);
      end
      now++;
      step("t2.rering", to_bcd(now), 0, 24'h0, 0, 0, 2'b10, 2'(i), 0, 0, 24'h000003);
    end
    now++;
    step("t2.fourth", to_bcd(now), 0, 24'h0, 1, 0, 2'b10, 2'd3, 0, 0, 24'h000003);
    now++;
    step("t3.stopsnz", to_bcd(now), 0, 24'h0, 1, 1, 2'b01, 2'd0, 0, 0, 24'h000003);

    // Unanswered ring times out after four cycles
    step("t4.set", 24'h000058, 1, 24'h000100, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000100);
    step("t4.armed", 24'h000059, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000100);
    step("t4.ring", 24'h000100, 0, 24'h0, 0, 0, 2'b10, 2'd0, 0, 0, 24'h000100);
    for (int k = 1; k <= 3; k++)
      step("t4.ringing", 24'h000100 + 24'(k), 0, 24'h0, 0, 0, 2'b10, 2'd0, 0, 0, 24'h000100);
    step("t4.timeout", 24'h000104, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 1, 24'h000100);
    step("t4.sticky", 24'h000105, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 1, 24'h000100);
    step("t4.sticky", 24'h000106, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 1, 24'h000100);
    step("t4.stop", 24'h000107, 0, 24'h0, 0, 1, 2'b01, 2'd0, 0, 0, 24'h000100);

    // Invalid loads rejected; alarm at 00:00:00 fires on the midnight wrap
    step("t5.badhour", 24'h000108, 1, 24'h245900, 0, 0, 2'b01, 2'd0, 1, 0, 24'h000100);
    step("t5.errclr", 24'h000109, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000100);
    step("t5.badmin", 24'h000110, 1, 24'h126000, 0, 0, 2'b01, 2'd0, 1, 0, 24'h000100);
    step("t5.wrapset", 24'h235958, 1, 24'h000000, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000000);
    step("t5.wraparm", 24'h235959, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h000000);
    step("t5.wrapring", 24'h000000, 0, 24'h0, 0, 0, 2'b10, 2'd0, 0, 0, 24'h000000);
    step("t5.wrapstop", 24'h000001, 0, 24'h0, 0, 1, 2'b01, 2'd0, 0, 0, 24'h000000);
    step("t5.load", 24'h061400, 1, 24'h061500, 0, 0, 2'b01, 2'd0, 0, 0, 24'h061500);

    // Clock held at the alarm time rings once only
    step("t6.armed", 24'h061459, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h061500);
    for (int k = 0; k < 6; k++)
      step("t6.hold", 24'h061500, 0, 24'h0, 0, 0, (k < 4) ? 2'b10 : 2'b01, 2'd0, 0,
           (k >= 4), 24'h061500);
    step("t6.stop", 24'h061501, 0, 24'h0, 0, 1, 2'b01, 2'd0, 0, 0, 24'h061500);
    bus.alarm_en = 1'b0;
    step("t6.disable", 24'h061502, 0, 24'h0, 0, 0, 2'b00, 2'd0, 0, 0, 24'h061500);
    bus.alarm_en = 1'b1;
    step("t6.enable", 24'h061503, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h061500);
    step("t6.rearm", 24'h061459, 0, 24'h0, 0, 0, 2'b01, 2'd0, 0, 0, 24'h061500);
    step("t6.ring", 24'h061500, 0, 24'h0, 0, 0, 2'b10, 2'd0, 0, 0, 24'h061500);

    // Asynchronous reset between edges while ringing
    #3;
    reset_n = 1'b0;
    #1;
    check("areset.ringing",    bus.ringing,    1'b0);
    check("areset.state",      bus.state,      2'b00);
    check("areset.alarm_time", bus.alarm_time, 24'h000000);
    check("scoreboard.drained", exp_q.size(), 0);
    #4;
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
